// File: rtl/segment_ex_mem.sv
// rtl/segment_ex_mem.sv - EX/MEM pipeline segment register with stall/flush (optional SEGMENT_EX_MEM_VALID_EN)
module segment_ex_mem #(
    parameter int DATA_W     = 21,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  MemToReg_in,
    input  logic                  MemRead_in,
    input  logic                  MemWrite_in,
    input  logic                  RegWrite_in,
    input  logic [DATA_W-1:0]     alu_in,
    input  logic [DATA_W-1:0]     RD3_in,
    input  logic [REG_ADDR_W-1:0] RR3_in,
    output logic                  MemToReg_out,
    output logic                  MemRead_out,
    output logic                  MemWrite_out,
    output logic                  RegWrite_out,
    output logic [DATA_W-1:0]     alu_out,
    output logic [DATA_W-1:0]     RD3_out,
`ifdef SEGMENT_EX_MEM_VALID_EN
    output logic                  valid_out,
`endif
    output logic [REG_ADDR_W-1:0] RR3_out
);

    logic                  mem_to_reg_q, mem_to_reg_d;
    logic                  mem_read_q,   mem_read_d;
    logic                  mem_write_q,  mem_write_d;
    logic                  reg_write_q,  reg_write_d;
    logic [DATA_W-1:0]     alu_q,        alu_d;
    logic [DATA_W-1:0]     rd3_q,        rd3_d;
    logic [REG_ADDR_W-1:0] rr3_q,        rr3_d;
    logic                  valid_q,      valid_d;

    // Next-state selection: flush inserts a bubble, stall holds, otherwise load from EX
    always_comb begin
        mem_to_reg_d = mem_to_reg_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        reg_write_d  = reg_write_q;
        alu_d        = alu_q;
        rd3_d        = rd3_q;
        rr3_d        = rr3_q;
        valid_d      = valid_q;
        if (flush) begin
            mem_to_reg_d = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            reg_write_d  = 1'b0;
            alu_d        = '0;
            rd3_d        = '0;
            rr3_d        = '0;
            valid_d      = 1'b0;
        end else if (!stall) begin
            mem_to_reg_d = MemToReg_in;
            mem_read_d   = MemRead_in;
            mem_write_d  = MemWrite_in;
            reg_write_d  = RegWrite_in;
            alu_d        = alu_in;
            rd3_d        = RD3_in;
            rr3_d        = RR3_in;
            valid_d      = 1'b1;
        end
    end

    // Segment register; asynchronous reset clears everything without waiting for a clock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_to_reg_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            alu_q        <= '0;
            rd3_q        <= '0;
            rr3_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            mem_to_reg_q <= mem_to_reg_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            reg_write_q  <= reg_write_d;
            alu_q        <= alu_d;
            rd3_q        <= rd3_d;
            rr3_q        <= rr3_d;
            valid_q      <= valid_d;
        end
    end

    assign MemToReg_out = mem_to_reg_q;
    assign alu_out      = alu_q;
    assign RD3_out      = rd3_q;
    assign RR3_out      = rr3_q;

`ifdef SEGMENT_EX_MEM_VALID_EN
    // Side-effecting controls are gated by valid so a bubble can never write memory or registers
    assign valid_out    = valid_q;
    assign MemRead_out  = mem_read_q  & valid_q;
    assign MemWrite_out = mem_write_q & valid_q;
    assign RegWrite_out = reg_write_q & valid_q;
`else
    // valid only matters when the gated output is built; keep it referenced for lint
    logic unused_valid;
    assign unused_valid = valid_q;
    assign MemRead_out  = mem_read_q;
    assign MemWrite_out = mem_write_q;
    assign RegWrite_out = reg_write_q;
`endif

endmodule

// File: tb/tb_segment_ex_mem.sv
// tb/tb_segment_ex_mem.sv - randomized self-checking bench for segment_ex_mem
module tb_segment_ex_mem;

    localparam int DW = 21;
    localparam int AW = 4;
`ifdef SEGMENT_EX_MEM_VALID_EN
    localparam int VW = 4 + 2*DW + AW + 1;
`else
    localparam int VW = 4 + 2*DW + AW;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          stall, flush;
    logic          MemToReg_in, MemRead_in, MemWrite_in, RegWrite_in;
    logic [DW-1:0] alu_in, RD3_in;
    logic [AW-1:0] RR3_in;
    logic          MemToReg_out, MemRead_out, MemWrite_out, RegWrite_out;
    logic [DW-1:0] alu_out, RD3_out;
    logic [AW-1:0] RR3_out;
`ifdef SEGMENT_EX_MEM_VALID_EN
    logic          valid_out;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: what the MEM stage should currently see
    logic [3:0]    m_ctl;   // {MemToReg, MemRead, MemWrite, RegWrite}
    logic [DW-1:0] m_alu, m_rd3;
    logic [AW-1:0] m_rr3;
    logic          m_valid;

    always #5 clk = ~clk;

    segment_ex_mem #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .MemToReg_in(MemToReg_in), .MemRead_in(MemRead_in),
        .MemWrite_in(MemWrite_in), .RegWrite_in(RegWrite_in),
        .alu_in(alu_in), .RD3_in(RD3_in), .RR3_in(RR3_in),
        .MemToReg_out(MemToReg_out), .MemRead_out(MemRead_out),
        .MemWrite_out(MemWrite_out), .RegWrite_out(RegWrite_out),
        .alu_out(alu_out), .RD3_out(RD3_out),
`ifdef SEGMENT_EX_MEM_VALID_EN
        .valid_out(valid_out),
`endif
        .RR3_out(RR3_out)
    );

    function automatic logic [VW-1:0] obs();
`ifdef SEGMENT_EX_MEM_VALID_EN
        return {MemToReg_out, MemRead_out, MemWrite_out, RegWrite_out,
                alu_out, RD3_out, RR3_out, valid_out};
`else
        return {MemToReg_out, MemRead_out, MemWrite_out, RegWrite_out,
                alu_out, RD3_out, RR3_out};
`endif
    endfunction

    function automatic logic [VW-1:0] expv();
`ifdef SEGMENT_EX_MEM_VALID_EN
        return {m_ctl[3], m_ctl[2] & m_valid, m_ctl[1] & m_valid, m_ctl[0] & m_valid,
                m_alu, m_rd3, m_rr3, m_valid};
`else
        return {m_ctl, m_alu, m_rd3, m_rr3};
`endif
    endfunction

    task automatic model_clear();
        m_ctl = '0; m_alu = '0; m_rd3 = '0; m_rr3 = '0; m_valid = 1'b0;
    endtask

    // One rising edge as the MEM stage should experience it, then settle to the falling edge
    task automatic step();
        if (!rst || flush) model_clear();
        else if (!stall) begin
            m_ctl   = {MemToReg_in, MemRead_in, MemWrite_in, RegWrite_in};
            m_alu   = alu_in;
            m_rd3   = RD3_in;
            m_rr3   = RR3_in;
            m_valid = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] c, input logic [DW-1:0] a,
                         input logic [DW-1:0] d, input logic [AW-1:0] r);
        {MemToReg_in, MemRead_in, MemWrite_in, RegWrite_in} = c;
        alu_in = a; RD3_in = d; RR3_in = r;
    endtask

    task automatic drive_random();
        drive(4'($urandom), DW'($urandom), DW'($urandom), AW'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        drive('0, '0, '0, '0);
        model_clear();
        @(negedge clk);
        vectors++;
        if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL reset_initial: got %h expected %h", obs(), expv());
        end
        rst = 1'b1;
        drive(4'hF, 21'h0ABCDE, 21'h012345, 4'hA);
        step();
        vectors++;
        if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL reset_preload: got %h expected %h", obs(), expv());
        end
        #2 rst = 1'b0;
        model_clear();
        #1;
        vectors++;
        if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL reset_async_clear: got %h expected %h", obs(), expv());
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            drive(4'hF, 21'h1FFFFF, 21'h155555, 4'hF);
            step();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL reset_held_%0d: got %h expected %h", i, obs(), expv());
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_load();
        drive(4'b1101, 21'd100, 21'd200, 4'd5);
        step();
        vectors++;
        if (obs() !== expv() || alu_out !== 21'd100 || RR3_out !== 4'd5 ||
            {MemToReg_out, MemRead_out, MemWrite_out, RegWrite_out} !== 4'b1101) begin
            miscompares++;
            $display("FAIL load: got %h expected %h", obs(), expv());
        end
        drive(4'b1111, 21'd300, 21'd400, 4'd6);
        step();
        vectors++;
        if (obs() !== expv() || RD3_out !== 21'd400 || MemWrite_out !== 1'b1) begin
            miscompares++;
            $display("FAIL update: got %h expected %h", obs(), expv());
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        drive(4'b1111, 21'd7, 21'd400, 4'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (obs() !== expv() || alu_out !== 21'd300 || RR3_out !== 4'd6) begin
                miscompares++;
                $display("FAIL stall_hold_%0d: got %h expected %h", i, obs(), expv());
            end
        end
        stall = 1'b0;
        step();
        vectors++;
        if (obs() !== expv() || alu_out !== 21'd7 || RR3_out !== 4'd2) begin
            miscompares++;
            $display("FAIL stall_release: got %h expected %h", obs(), expv());
        end
    endtask

    task automatic test_flush_priority();
        stall = 1'b1; flush = 1'b1;
        drive(4'hF, 21'h1F0F0F, 21'h0F0F0F, 4'h9);
        step();
        vectors++;
        if (obs() !== expv() || obs() !== '0) begin
            miscompares++;
            $display("FAIL flush_priority: got %h expected %h", obs(), expv());
        end
        stall = 1'b0; flush = 1'b0;
        step();
        vectors++;
        if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL flush_recover: got %h expected %h", obs(), expv());
        end
    endtask

    task automatic test_async_reset();
        drive(4'b0110, 21'h1FFFFF, 21'h1AAAAA, 4'hC);
        #2 rst = 1'b0;
        model_clear();
        #1;
        vectors++;
        if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL async_mid: got %h expected %h", obs(), expv());
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        vectors++;
        if (obs() !== expv() || alu_out !== 21'h1FFFFF) begin
            miscompares++;
            $display("FAIL async_release_load: got %h expected %h", obs(), expv());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            drive_random();
            #1;
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL random_no_comb_path_%0d: got %h expected %h", i, obs(), expv());
            end
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b0;
                model_clear();
                #1;
                vectors++;
                if (obs() !== expv()) begin
                    miscompares++;
                    $display("FAIL random_async_%0d: got %h expected %h", i, obs(), expv());
                end
            end
            step();
            rst = 1'b1;
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL random_%0d: got %h expected %h", i, obs(), expv());
            end
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_flush_priority();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
